pixel_work_gen: RTL and testbench

PIXEL_WORK_GEN -- requirements
Module: pixel_work_gen

---
 rtl/pixel_work_gen_pkg.sv | 29 ++
 rtl/raster_counter.sv | 67 ++++++
 rtl/pixel_work_gen.sv | 128 ++++++++++++
 tb/tb_pixel_work_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_work_gen_pkg.sv
// Shared definitions for the pixel work generator and its queue consumer:
// FSM state encoding, default geometry/width parameters and the bit
// offsets of the fields inside a packed work item {y, x, c_re, c_im}.
package pixel_work_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pwg_state_e;

    localparam int PWG_H_RES   = 640;
    localparam int PWG_V_RES   = 480;
    localparam int PWG_COORD_W = 32;
    localparam int PWG_XY_W    = 10;

    // Packed work item layout for the default widths, y in the MSBs.
    localparam int ITEM_C_IM_LSB = 0;
    localparam int ITEM_C_RE_LSB = PWG_COORD_W;
    localparam int ITEM_X_LSB    = 2 * PWG_COORD_W;
    localparam int ITEM_Y_LSB    = 2 * PWG_COORD_W + PWG_XY_W;
    localparam int ITEM_W        = 2 * PWG_COORD_W + 2 * PWG_XY_W;

    // Width of a packed work item for arbitrary index/coordinate widths.
    function automatic int pwg_item_w(input int xy_w, input int coord_w);
        return 2 * xy_w + 2 * coord_w;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel index counter. Cleared at frame start, advanced
// once per accepted work item, wrapping x at the end of each line.
module raster_counter
    import pixel_work_gen_pkg::*;
#(
    parameter int H_RES = PWG_H_RES,
    parameter int V_RES = PWG_V_RES,
    parameter int XY_W  = PWG_XY_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [XY_W-1:0] x_o,
    output logic [XY_W-1:0] y_o,
    output logic            x_last_o,
    output logic            frame_last_o
);

    localparam logic [XY_W-1:0] X_MAX = XY_W'(H_RES - 1);
    localparam logic [XY_W-1:0] Y_MAX = XY_W'(V_RES - 1);
    localparam logic [XY_W-1:0] ONE   = XY_W'(1);

    logic [XY_W-1:0] x_q, x_d;
    logic [XY_W-1:0] y_q, y_d;

    // Next-index computation: clear wins over advance, x wraps into y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                if (y_q == Y_MAX) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + ONE;
                end
            end else begin
                x_d = x_q + ONE;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Index registers with synchronous reset to the frame origin.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign x_last_o     = (x_q == X_MAX);
    assign frame_last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/pixel_work_gen.sv
// Pixel work generator: walks a frame in raster order and pushes one work
// item {y, x, c_re, c_im} per pixel into a downstream queue. Coordinates
// are stepped incrementally (add/subtract only), wrapping two's complement.
module pixel_work_gen
    import pixel_work_gen_pkg::*;
#(
    parameter int H_RES   = PWG_H_RES,
    parameter int V_RES   = PWG_V_RES,
    parameter int COORD_W = PWG_COORD_W,
    parameter int XY_W    = PWG_XY_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [COORD_W-1:0]             re_min,
    input  logic [COORD_W-1:0]             im_max,
    input  logic [COORD_W-1:0]             step,
    input  logic                           q_full,
    output logic                           q_write,
    output logic [2*XY_W+2*COORD_W-1:0]    q_data,
    output logic                           busy,
    output logic                           done
);

    pwg_state_e state_q, state_d;

    // Latched frame parameters; c_im_q carries the latched im_max.
    logic [COORD_W-1:0] re_min_q, re_min_d;
    logic [COORD_W-1:0] step_q,   step_d;
    logic [COORD_W-1:0] c_re_q,   c_re_d;
    logic [COORD_W-1:0] c_im_q,   c_im_d;

    logic            load_s;
    logic            x_last_s;
    logic            frame_last_s;
    logic [XY_W-1:0] x_s;
    logic [XY_W-1:0] y_s;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XY_W  (XY_W)
    ) u_raster (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (load_s),
        .advance_i    (q_write),
        .x_o          (x_s),
        .y_o          (y_s),
        .x_last_o     (x_last_s),
        .frame_last_o (frame_last_s)
    );

    // Push request: an item is offered only while running, not blocked by
    // a full queue and not being aborted this cycle.
    always_comb begin
        q_write = (state_q == ST_RUN) && !q_full && !abort;
    end

    // Next-state and coordinate stepping; start beats abort in IDLE.
    always_comb begin
        state_d  = state_q;
        re_min_d = re_min_q;
        step_d   = step_q;
        c_re_d   = c_re_q;
        c_im_d   = c_im_q;
        load_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    load_s   = 1'b1;
                    re_min_d = re_min;
                    step_d   = step;
                    c_re_d   = re_min;
                    c_im_d   = im_max;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (q_write) begin
                    if (frame_last_s) begin
                        state_d = ST_DONE;
                    end else if (x_last_s) begin
                        c_re_d = re_min_q;
                        c_im_d = c_im_q - step_q;
                    end else begin
                        c_re_d = c_re_q + step_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and coordinate registers; reset clears everything to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            re_min_q <= '0;
            step_q   <= '0;
            c_re_q   <= '0;
            c_im_q   <= '0;
        end else begin
            state_q  <= state_d;
            re_min_q <= re_min_d;
            step_q   <= step_d;
            c_re_q   <= c_re_d;
            c_im_q   <= c_im_d;
        end
    end

    assign q_data = {y_s, x_s, c_re_q, c_im_q};
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_pixel_work_gen.sv
// Scoreboard bench for pixel_work_gen on a 4x3 frame: the stimulus pushes
// every expected work item of a frame into a queue, an independent monitor
// pops and compares each item the DUT offers.
module tb_pixel_work_gen;
    import pixel_work_gen_pkg::*;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CW = 32;
    localparam int XW = 10;
    localparam int IW = 2 * XW + 2 * CW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] re_min;
    logic [CW-1:0] im_max;
    logic [CW-1:0] step;
    logic          q_full;
    logic          q_write;
    logic [IW-1:0] q_data;
    logic          busy;
    logic          done;

    int cmp_cnt  = 0;
    int err_cnt  = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int done_exp = 0;
    bit full_rand = 1'b0;

    logic [IW-1:0] exp_q[$];

    pixel_work_gen #(.H_RES(H), .V_RES(V), .COORD_W(CW), .XY_W(XW)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .re_min (re_min),
        .im_max (im_max),
        .step   (step),
        .q_full (q_full),
        .q_write(q_write),
        .q_data (q_data),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference item: coordinates from the pixel position by plain arithmetic.
    function automatic logic [IW-1:0] make_item(input int x, input int y,
                                                input logic [CW-1:0] re,
                                                input logic [CW-1:0] im,
                                                input logic [CW-1:0] st);
        logic [IW-1:0] it;
        logic [CW-1:0] xv;
        logic [CW-1:0] yv;
        xv = CW'(x);
        yv = CW'(y);
        it = '0;
        it[ITEM_Y_LSB +: XW]    = XW'(y);
        it[ITEM_X_LSB +: XW]    = XW'(x);
        it[ITEM_C_RE_LSB +: CW] = re + xv * st;
        it[ITEM_C_IM_LSB +: CW] = im - yv * st;
        return it;
    endfunction

    task automatic push_frame(input logic [CW-1:0] re, input logic [CW-1:0] im,
                              input logic [CW-1:0] st);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                exp_q.push_back(make_item(x, y, re, im, st));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Issue a one-cycle start with the given frame parameters.
    task automatic start_frame(input logic [CW-1:0] re, input logic [CW-1:0] im,
                               input logic [CW-1:0] st);
        push_frame(re, im, st);
        done_exp++;
        start  = 1'b1;
        re_min = re;
        im_max = im;
        step   = st;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for the frame-complete pulse; optionally hammer start
    // and the parameter inputs while the frame runs.
    task automatic wait_done(input bit perturb);
        int prev;
        int n;
        prev = done_cnt;
        n = 0;
        while (done_cnt == prev && n < 500) begin
            if (perturb) begin
                start  = 1'($urandom_range(0, 1));
                re_min = $urandom;
                im_max = $urandom;
                step   = $urandom;
            end
            @(posedge clock);
            #1;
            n++;
        end
        start = 1'b0;
        check("frame_done_seen", 128'(done_cnt - prev), 128'd1);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        idle(2);
    endtask

    task automatic wait_accepts(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("accepts_reached", 128'(acc_cnt), 128'(target));
    endtask

    // Downstream queue-full driver.
    initial begin
        q_full = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            q_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: pops and compares offered items, checks stalls and done.
    bit            pend = 1'b0;
    logic [IW-1:0] pend_data;
    bit            chk_busy_next = 1'b0;
    logic [IW-1:0] exp_item;

    always @(negedge clock) begin
        if (q_full)
            check("qwrite_while_full", 128'(q_write), 128'd0);
        if (q_write) begin
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_item: got %h expected none", q_data);
            end else begin
                exp_item = exp_q.pop_front();
                check("item", 128'(q_data), 128'(exp_item));
            end
            acc_cnt++;
        end
        if (pend && busy)
            check("stall_stable", 128'(q_data), 128'(pend_data));
        pend      = busy && !done && !q_write && !abort && !reset;
        pend_data = q_data;
        if (chk_busy_next)
            check("busy_after_done", 128'(busy), 128'd0);
        chk_busy_next = 1'b0;
        if (done) begin
            done_cnt++;
            check("queue_empty_at_done", 128'(exp_q.size()), 128'd0);
            chk_busy_next = 1'b1;
        end
    end

    initial begin
        int base;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        re_min = '0;
        im_max = '0;
        step   = '0;
        idle(3);
        check("reset_qwrite", 128'(q_write), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_qdata", 128'(q_data), 128'd0);
        reset = 1'b0;
        idle(2);

        // Basic frame: -2.0, 1.0, step 0.25 in Q4.28, queue never full.
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h0400_0000);
        wait_done(1'b0);

        // Same frame with random back-pressure.
        full_rand = 1'b1;
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h0400_0000);
        wait_done(1'b0);

        // Abort after the fifth accepted item, then a fresh frame.
        full_rand = 1'b0;
        base = acc_cnt;
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h0400_0000);
        wait_accepts(base + 5);
        abort = 1'b1;
        exp_q.delete();
        done_exp--;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_qwrite", 128'(q_write), 128'd0);
        idle(3);
        start_frame(32'h0123_4567, 32'hF000_0000, 32'h0010_0000);
        wait_done(1'b0);

        // Reset after the seventh accepted item, then a fresh frame.
        full_rand = 1'b1;
        base = acc_cnt;
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h0400_0000);
        wait_accepts(base + 7);
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        done_exp--;
        check("midreset_qwrite", 128'(q_write), 128'd0);
        check("midreset_busy", 128'(busy), 128'd0);
        check("midreset_done", 128'(done), 128'd0);
        check("midreset_qdata", 128'(q_data), 128'd0);
        reset = 1'b0;
        idle(2);
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h0400_0000);
        wait_done(1'b0);

        // Real-coordinate wrap past the positive limit.
        start_frame(32'h7FFF_FFF0, 32'h0000_0100, 32'h0000_0010);
        wait_done(1'b0);

        // Random parameters with start/parameter churn during the frame.
        for (int k = 0; k < 3; k++) begin
            start_frame($urandom, $urandom, $urandom);
            wait_done(1'b1);
        end

        idle(3);
        check("done_count", 128'(done_cnt), 128'(done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
